// File: rtl/vram_pixel_writer.sv
// rtl/vram_pixel_writer.sv - queued single-pixel read-modify-write painter for the 64x512 VRAM
module vram_pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_VALID,
    output logic             out_READY,
    input  logic [5:0]       in_X,
    input  logic [5:0]       in_Y,
    input  logic [PIX_W-1:0] in_COLOR,
    input  logic             in_VRAM_AVAILABLE,
    output logic             out_VRAM_RD,
    output logic             out_VRAM_WR,
    output logic [5:0]       out_VRAM_ADDR,
    output logic [511:0]     out_VRAM_WDATA,
    input  logic [511:0]     in_VRAM_RDATA,
    input  logic             in_VRAM_RDATA_VALID,
    output logic             out_BUSY
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 12 + PIX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_REQ  = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_WR      = 2'd3;

    logic [1:0]       state;
    logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [EW-1:0]    head;
    logic [5:0]       op_x;
    logic [PIX_W-1:0] op_c;
    logic [5:0]       addr_q;
    logic [511:0]     wdata_q;
    logic [511:0]     merged;
    logic [8:0]       bit_lo;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == S_IDLE) && !empty;
    // A pop frees a slot this very cycle, so a full FIFO may still accept.
    assign out_READY = !full || pop;
    assign push      = in_VALID && out_READY;
    assign head      = fifo_mem[rd_ptr];

    assign out_VRAM_RD    = (state == S_RD_REQ) && in_VRAM_AVAILABLE;
    assign out_VRAM_WR    = (state == S_WR) && in_VRAM_AVAILABLE;
    assign out_VRAM_ADDR  = addr_q;
    assign out_VRAM_WDATA = wdata_q;
    assign out_BUSY       = (state != S_IDLE) || !empty;

    assign bit_lo = 9'(op_x) * 9'(PIX_W);

    always_comb begin
        merged = in_VRAM_RDATA;
        merged[bit_lo +: PIX_W] = op_c;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_Y, in_X, in_COLOR};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            op_x    <= '0;
            op_c    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        addr_q <= head[EW-1 -: 6];
                        op_x   <= head[PIX_W +: 6];
                        op_c   <= head[PIX_W-1:0];
                        state  <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (in_VRAM_AVAILABLE) state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (in_VRAM_RDATA_VALID) begin
                        wdata_q <= merged;
                        state   <= S_WR;
                    end
                end
                S_WR: begin
                    if (in_VRAM_AVAILABLE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
